// File: rtl/serial_add_collector.sv
// Bit-serial adder back end: one full adder plus a carry flop, LSB-first sum deserialiser.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             done_o,
`ifdef SERIAL_ADD_OVF_EN
    output logic             busy_o,
    output logic             ovf_o
`else
    output logic             busy_o
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             carry_reg, carry_next;
    logic [WIDTH-1:0] partial_reg, partial_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_reg, ovf_next;
`endif

    logic             s_bit;
    logic             c_new;
    logic [WIDTH-1:0] shifted;

    assign s_bit = a_i ^ b_i ^ carry_reg;
    assign c_new = (a_i & b_i) | (a_i & carry_reg) | (b_i & carry_reg);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shifted[gi] = partial_reg[gi+1];
        end
    endgenerate
    assign shifted[WIDTH-1] = s_bit;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        carry_next   = carry_reg;
        partial_next = partial_reg;
        sum_next     = sum_reg;
        cout_next    = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
        ovf_next     = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next   = ADD;
                    count_next   = '0;
                    carry_next   = 1'b0;
                    partial_next = '0;
                end
            end
            ADD: begin
                if (start_i) begin
                    count_next   = '0;
                    carry_next   = 1'b0;
                    partial_next = '0;
                end else if (bit_valid_i) begin
                    carry_next   = c_new;
                    partial_next = shifted;
                    if (count_reg == LAST) begin
                        state_next = DONE;
                        count_next = '0;
                        sum_next   = shifted;
                        cout_next  = c_new;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_reg is the carry into the MSB at this point
                        ovf_next   = carry_reg ^ c_new;
`endif
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    state_next   = ADD;
                    count_next   = '0;
                    carry_next   = 1'b0;
                    partial_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        done_next = (state_next == DONE);
        busy_next = (state_next == ADD);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            carry_reg   <= 1'b0;
            partial_reg <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            carry_reg   <= carry_next;
            partial_reg <= partial_next;
            sum_reg     <= sum_next;
            cout_reg    <= cout_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg     <= ovf_next;
`endif
        end
    end

    assign sum_o   = sum_reg;
    assign carry_o = cout_reg;
    assign done_o  = done_reg;
    assign busy_o  = busy_reg;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o   = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_collector.sv
// Bench for serial_add_collector: vector table plus hand sequences, done-driven scoreboard.
module tb_serial_add_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a = 1'b0;
    logic         b = 1'b0;
    logic [W-1:0] sum;
    logic         carry;
    logic         done;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_collector #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .start_i    (start),
        .bit_valid_i(bit_valid),
        .a_i        (a),
        .b_i        (b),
        .sum_o      (sum),
        .carry_o    (carry),
        .done_o     (done),
`ifdef SERIAL_ADD_OVF_EN
        .busy_o     (busy),
        .ovf_o      (ovf)
`else
        .busy_o     (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         gaps;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
        logic         exp_ovf;
    } vec_t;

    res_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           dones = 0;
    int           pushes = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_carry = 1'b0;
    logic         prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            dones++;
            if (prev_done) begin
                tests++; fails++;
                $display("FAIL done_width: done high two cycles at %0t", $time);
            end
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: sum %0h with empty scoreboard at %0t", sum, $time);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("sb_sum", 32'(sum), 32'(e.sum));
                chk("sb_carry", 32'(carry), 32'(e.carry));
`ifdef SERIAL_ADD_OVF_EN
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
                $display("[TB] done sum=%02h carry=%0b expected sum=%02h carry=%0b", sum, carry, e.sum, e.carry);
            end
        end
        prev_done = done;
    end

    task automatic begin_add(input logic bv);
        start = 1'b1;
        bit_valid = bv;
        a = 1'b1;
        b = 1'b1;
        step();
        start = 1'b0;
        bit_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
    endtask

    task automatic send_bits(input logic [W-1:0] va, input logic [W-1:0] vb, input int n,
                             input logic gaps, input res_t exp);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            a = va[i];
            b = vb[i];
            if (i == W - 1) begin
                sb.push_back(exp);
                pushes++;
            end
            step();
            bit_valid = 1'b0;
            a = 1'($urandom);
            b = 1'($urandom);
            if (i == W - 1) begin
                chk("done_latency", 32'(done), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
                last_sum = exp.sum;
                last_carry = exp.carry;
            end else begin
                chk("done_mid", 32'(done), 32'd0);
                chk("busy_mid", 32'(busy), 32'd1);
                chk("sum_held_mid", 32'(sum), 32'(last_sum));
                chk("carry_held_mid", 32'(carry), 32'(last_carry));
                if (gaps && (i == 1 || i == 4)) begin
                    for (int g = 0; g < 3; g++) begin
                        step();
                        chk("done_gap", 32'(done), 32'd0);
                        chk("busy_gap", 32'(busy), 32'd1);
                    end
                end
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        res_t e;
        e.sum = v.exp_sum;
        e.carry = v.exp_carry;
        e.ovf = v.exp_ovf;
        $display("[TB] add %02h + %02h gaps=%0b", v.a, v.b, v.gaps);
        begin_add(1'b0);
        send_bits(v.a, v.b, W, v.gaps, e);
    endtask

    vec_t vecs[6];

    initial begin
        res_t e;
        vec_t v;
        vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};

        step();
        step();
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            step();
            run_vec(vecs[i]);
        end

        // Complete 10+20, then abort a partial 0A+0B with start and bit_valid together.
        step();
        v = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        run_vec(v);
        step();
        $display("[TB] abort after 4 bits, restart 0A + 0B");
        e = '{8'h00, 1'b0, 1'b0};
        begin_add(1'b0);
        send_bits(8'h0A, 8'h0B, 4, 1'b0, e);
        begin_add(1'b1);
        e = '{8'h15, 1'b0, 1'b0};
        send_bits(8'h0A, 8'h0B, W, 1'b0, e);
        chk("abort_final_sum", 32'(sum), 32'h15);

        // Back-to-back: start sampled in the DONE cycle.
        step();
        v = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        run_vec(v);
        chk("b2b_first_sum", 32'(sum), 32'h02);
        v = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        run_vec(v);
        chk("b2b_second_carry", 32'(carry), 32'd1);

        // Reset in the middle of AA+55.
        step();
        $display("[TB] reset after 5 bits of AA + 55");
        e = '{8'h00, 1'b0, 1'b0};
        begin_add(1'b0);
        send_bits(8'hAA, 8'h55, 5, 1'b0, e);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midreset_sum", 32'(sum), 32'd0);
        chk("midreset_carry", 32'(carry), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        last_sum = '0;
        last_carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            step();
            chk("postreset_busy", 32'(busy), 32'd0);
        end
        bit_valid = 1'b0;

        // Idle: bit_valid toggles without start after a completed addition.
        v = '{8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0};
        run_vec(v);
        for (int i = 0; i < 8; i++) begin
            bit_valid = i[0];
            a = 1'($urandom);
            b = 1'($urandom);
            step();
            if (i > 0) begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_sum_held", 32'(sum), 32'h64);
            end
        end
        bit_valid = 1'b0;
        step();
        step();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(pushes));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
